// File: rtl/button_input_conditioner_if.sv
// Board-pin bundle between the raw buttons/switches and the conditioner.
// No valid/ready handshake: every output is a level except step_pulse, a one-cycle strobe.
interface button_input_conditioner_if;
   logic       s_button;
   logic       w_button;
   logic       switch0;
   logic       switch1;
   logic       switch2;
   logic       switch3;
   logic       step_pulse;
   logic       cpu_reset;
   logic [3:0] sw_clean;
   logic       s_held;
   logic       w_held;

   modport master (
      output s_button, w_button, switch0, switch1, switch2, switch3,
      input  step_pulse, cpu_reset, sw_clean, s_held, w_held
   );

   modport slave (
      input  s_button, w_button, switch0, switch1, switch2, switch3,
      output step_pulse, cpu_reset, sw_clean, s_held, w_held
   );
endinterface

// File: rtl/button_input_conditioner.sv
// Synchronizes and debounces the step/reset buttons and four switches, then derives a
// single-cycle step pulse and a stretched active-high cpu_reset for the integration top.
module button_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5,
   parameter int RESET_STRETCH   = 4,
   parameter int STR_W           = 3
) (
   input  logic                       clk,
   input  logic                       RESET,
   button_input_conditioner_if.slave  io,
   output logic                       dbg_state
);

   typedef enum logic {ST_HOLD = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [STR_W-1:0] STR_LOAD = STR_W'(RESET_STRETCH - 1);

   // Bit order: {switch3, switch2, switch1, switch0, w_button, s_button}
   logic [5:0] raw_in;
   logic [5:0] sync1_q;
   logic [5:0] sync2_q;
   logic [5:0] deb;

   assign raw_in = {io.switch3, io.switch2, io.switch1, io.switch0, io.w_button, io.s_button};

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
      end
   end

   for (genvar g = 0; g < 6; g++) begin : g_deb
      logic [CNT_W-1:0] cnt_q;
      logic             deb_q;

      // Any sample matching the accepted level restarts the stability count.
      always_ff @(posedge clk or negedge RESET) begin
         if (!RESET) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
         end else if (sync2_q[g] == deb_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DEB_LAST) begin
            cnt_q <= '0;
            deb_q <= sync2_q[g];
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end

      assign deb[g] = deb_q;
   end

   logic s_held;
   logic w_held;
   assign s_held = deb[0];
   assign w_held = deb[1];

   state_t           state_q;
   state_t           state_d;
   logic [STR_W-1:0] str_q;
   logic [STR_W-1:0] str_d;
   logic             cpu_reset;

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_HOLD;
         str_q   <= STR_LOAD;
      end else begin
         state_q <= state_d;
         str_q   <= str_d;
      end
   end

   always_comb begin
      state_d = state_q;
      str_d   = str_q;
      case (state_q)
         ST_HOLD: begin
            if (w_held) begin
               str_d = STR_LOAD;
            end else if (str_q == '0) begin
               state_d = ST_RUN;
            end else begin
               str_d = str_q - 1'b1;
            end
         end
         ST_RUN: begin
            if (w_held) begin
               state_d = ST_HOLD;
               str_d   = STR_LOAD;
            end
         end
         default: begin
            state_d = ST_HOLD;
            str_d   = STR_LOAD;
         end
      endcase
   end

   assign cpu_reset = (state_q == ST_HOLD);
   assign dbg_state = state_q;

   // A rise seen while reset is active (or rising with it) is dropped, never deferred.
   logic s_held_q;
   logic step_q;

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         s_held_q <= 1'b0;
         step_q   <= 1'b0;
      end else begin
         s_held_q <= s_held;
         step_q   <= s_held & ~s_held_q & ~cpu_reset & ~w_held;
      end
   end

   assign io.step_pulse = step_q;
   assign io.cpu_reset  = cpu_reset;
   assign io.sw_clean   = deb[5:2];
   assign io.s_held     = s_held;
   assign io.w_held     = w_held;

endmodule
